legv8_dmem_responder: RTL and testbench

- Handshaked data-memory responder: the memory end of the load/store interface driven by the LEGv8 core for LDUR/STUR.
- Accepts one request at a time, waits a fixed, configurable number of cycles, commits the access and returns a response held until the core takes it.
- Replaces the zero-latency combinational data memory so multi-cycle and pipelined cores can be exercised against realistic memory timing.

---
 rtl/legv8_pkg.sv | 23 ++
 rtl/legv8_dmem_responder_if.sv | 31 +++
 rtl/legv8_dmem_array.sv | 31 +++
 rtl/legv8_dmem_responder.sv | 120 ++++++++++++
 tb/tb_legv8_dmem_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared types and helpers for the LEGv8 data-memory responder.
//   DWORD_W        width of one stored doubleword
//   BYTE_OFF_W     byte-offset bits inside a doubleword
//   dmem_state_e   responder FSM encodings (IDLE / WAIT / RESP)
//   addr_to_index  byte address -> doubleword index
package legv8_pkg;

  localparam int DWORD_W    = 64;
  localparam int BYTE_OFF_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Keeps the full address width so every upper bit takes part in the
  // range compare; callers slice the low bits for the array index.
  function automatic logic [DWORD_W-1:0] addr_to_index(input logic [DWORD_W-1:0] addr);
    return addr >> BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/legv8_dmem_responder_if.sv
// legv8_dmem_responder_if: load/store handshake bus between the LEGv8 core
// (master) and the data-memory responder (slave).
//   REQ_VALID/REQ_READY  request handshake
//   REQ_WRITE            1 = store, 0 = load
//   REQ_ADDR/REQ_WDATA   byte address and store data
//   RESP_VALID/RESP_READY response handshake
//   RESP_RDATA/RESP_ERR  load data and range/alignment error
interface legv8_dmem_responder_if;
  import legv8_pkg::*;

  logic               REQ_VALID;
  logic               REQ_READY;
  logic               REQ_WRITE;
  logic [DWORD_W-1:0] REQ_ADDR;
  logic [DWORD_W-1:0] REQ_WDATA;
  logic               RESP_VALID;
  logic               RESP_READY;
  logic [DWORD_W-1:0] RESP_RDATA;
  logic               RESP_ERR;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RESP_READY,
    input  REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RESP_READY,
    output REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR
  );

endinterface

// File: rtl/legv8_dmem_array.sv
// legv8_dmem_array: DEPTH_WORDS x 64-bit storage.
//   clk    clock
//   we     synchronous write enable
//   re     read strobe; rdata is sampled on the edge where re is high
//   addr   doubleword index
//   wdata  write data
//   rdata  registered read data, held until the next read strobe
module legv8_dmem_array
  import legv8_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int AW          = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [AW-1:0]      addr,
  input  logic [DWORD_W-1:0] wdata,
  output logic [DWORD_W-1:0] rdata
);

  logic [DWORD_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the storage array is deliberately not reset; contents survive RESET
  // and a reset port would also prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/legv8_dmem_responder.sv
// legv8_dmem_responder: handshaked data memory for LEGv8 LDUR/STUR with a
// fixed access latency.  One request is accepted in IDLE, the access commits
// LATENCY edges later, and the response is held until the core takes it.
//   CLOCK  clock, all state updates on the rising edge
//   RESET  synchronous, active-high reset
//   bus    slave side of legv8_dmem_responder_if (request/response handshakes)
//   BUSY   high while in WAIT or RESP
// Build option: define LEGV8_DMEM_ALIGN_CHECK_EN to flag addresses with
// nonzero byte offset as errors (no write, zero data).
module legv8_dmem_responder
  import legv8_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 2
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  legv8_dmem_responder_if.slave  bus,
  output logic                   BUSY
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RESP = ST_RESP;

  // Counter loads LATENCY-1 on acceptance so the commit edge lands exactly
  // LATENCY edges after the acceptance edge.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic               req_write_q;
  logic [DWORD_W-1:0] req_addr_q;
  logic [DWORD_W-1:0] req_wdata_q;
  logic               err_q;
  logic               load_ok_q;   // response carries array data

  logic [DWORD_W-1:0] idx;
  logic               addr_ok;
  logic               commit;
  logic               arr_we;
  logic               arr_re;
  logic [DWORD_W-1:0] arr_rdata;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    idx     = addr_to_index(req_addr_q);
    addr_ok = (idx < DWORD_W'(DEPTH_WORDS));
`ifdef LEGV8_DMEM_ALIGN_CHECK_EN
    if (req_addr_q[BYTE_OFF_W-1:0] != '0) addr_ok = 1'b0;
`endif
    commit  = (state == S_WAIT) && (cnt == '0);
    // A reset on the commit edge discards the store.
    arr_we  = commit && req_write_q && addr_ok && !RESET;
    arr_re  = commit && !req_write_q && addr_ok;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.REQ_VALID) begin
            req_write_q <= bus.REQ_WRITE;
            req_addr_q  <= bus.REQ_ADDR;
            req_wdata_q <= bus.REQ_WDATA;
            cnt         <= CNT_INIT;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            err_q     <= !addr_ok;
            load_ok_q <= addr_ok && !req_write_q;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.RESP_READY) begin
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  legv8_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (CLOCK),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (idx[AW-1:0]),
    .wdata (req_wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.REQ_READY  = (state == S_IDLE);
  assign bus.RESP_VALID = (state == S_RESP);
  // Array data is only exposed for successful loads; stores and errors read 0.
  assign bus.RESP_RDATA = load_ok_q ? arr_rdata : '0;
  assign bus.RESP_ERR   = err_q;
  assign BUSY           = (state != S_IDLE);

endmodule

// File: tb/tb_legv8_dmem_responder.sv
// tb_legv8_dmem_responder: self-checking bench for legv8_dmem_responder.
// Three instances share one clock: index 0 LATENCY=2, index 1 LATENCY=4,
// index 2 LATENCY=1, all with DEPTH_WORDS=32.  Expected responses are queued
// when a request is driven and compared when the response appears.
module tb_legv8_dmem_responder;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  localparam int LAT [3] = '{2, 4, 1};

  logic        clk = 1'b0;
  logic        rst         [3];
  logic        req_valid   [3];
  logic        req_write   [3];
  logic [63:0] req_addr    [3];
  logic [63:0] req_wdata   [3];
  logic        resp_ready  [3];
  logic        req_ready_o [3];
  logic        resp_valid_o[3];
  logic [63:0] resp_rdata_o[3];
  logic        resp_err_o  [3];
  logic        busy_o      [3];

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  legv8_dmem_responder_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign bus[g].REQ_VALID  = req_valid[g];
    assign bus[g].REQ_WRITE  = req_write[g];
    assign bus[g].REQ_ADDR   = req_addr[g];
    assign bus[g].REQ_WDATA  = req_wdata[g];
    assign bus[g].RESP_READY = resp_ready[g];
    assign req_ready_o[g]    = bus[g].REQ_READY;
    assign resp_valid_o[g]   = bus[g].RESP_VALID;
    assign resp_rdata_o[g]   = bus[g].RESP_RDATA;
    assign resp_err_o[g]     = bus[g].RESP_ERR;
  end

  legv8_dmem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut_l2 (
    .CLOCK(clk), .RESET(rst[0]), .bus(bus[0]), .BUSY(busy_o[0]));
  legv8_dmem_responder #(.DEPTH_WORDS(32), .LATENCY(4)) dut_l4 (
    .CLOCK(clk), .RESET(rst[1]), .bus(bus[1]), .BUSY(busy_o[1]));
  legv8_dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut_l1 (
    .CLOCK(clk), .RESET(rst[2]), .bus(bus[2]), .BUSY(busy_o[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k.  hold = cycles of RESP_READY=0
  // backpressure while the response is checked for stability.
  task automatic txn(input int k, input logic wr, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [63:0] exp_rd,
                     input logic exp_err, input int hold, input string tag);
    exp_t e;
    int   edges;
    @(negedge clk);
    check({tag, ".req_ready_idle"}, 64'(req_ready_o[k]), 64'd1);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);                       // acceptance edge has passed
    req_valid[k] = 1'b0;
    check({tag, ".busy_wait"}, 64'(busy_o[k]), 64'd1);
    check({tag, ".req_ready_wait"}, 64'(req_ready_o[k]), 64'd0);
    edges = 0;
    while (!resp_valid_o[k] && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check({tag, ".latency"}, 64'(edges), 64'(LAT[k]));
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      check({tag, ".hold_valid"}, 64'(resp_valid_o[k]), 64'd1);
      check({tag, ".hold_rdata"}, resp_rdata_o[k], e.rdata);
      check({tag, ".hold_err"}, 64'(resp_err_o[k]), 64'(e.err));
      check({tag, ".hold_req_ready"}, 64'(req_ready_o[k]), 64'd0);
      @(negedge clk);
    end
    check({tag, ".rdata"}, resp_rdata_o[k], e.rdata);
    check({tag, ".err"}, 64'(resp_err_o[k]), 64'(e.err));
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    check({tag, ".valid_after_hs"}, 64'(resp_valid_o[k]), 64'd0);
    check({tag, ".err_after_hs"}, 64'(resp_err_o[k]), 64'd0);
    check({tag, ".busy_after_hs"}, 64'(busy_o[k]), 64'd0);
  endtask

  logic        tp_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] tp_addr [4] = '{64'h20, 64'h28, 64'h20, 64'h28};
  logic [63:0] tp_data [4] = '{64'h0A0A_0A0A_1111_2222, 64'h0B0B_0B0B_3333_4444, 64'h0, 64'h0};
  logic [63:0] tp_exp  [4] = '{64'h0, 64'h0, 64'h0A0A_0A0A_1111_2222, 64'h0B0B_0B0B_3333_4444};

  initial begin
    exp_t e;
    int   issued;
    int   done;
    int   first_acc;
    int   last_hs;

    for (int k = 0; k < 3; k++) begin
      rst[k]        = 1'b1;
      req_valid[k]  = 1'b0;
      req_write[k]  = 1'b0;
      req_addr[k]   = '0;
      req_wdata[k]  = '0;
      resp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Reset state on every instance.
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d.req_ready", k), 64'(req_ready_o[k]), 64'd1);
      check($sformatf("reset%0d.resp_valid", k), 64'(resp_valid_o[k]), 64'd0);
      check($sformatf("reset%0d.rdata", k), resp_rdata_o[k], 64'd0);
      check($sformatf("reset%0d.err", k), 64'(resp_err_o[k]), 64'd0);
      check($sformatf("reset%0d.busy", k), 64'(busy_o[k]), 64'd0);
    end

    // Store then load back, load under 5 cycles of backpressure.
    txn(0, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, 0, "st_10");
    txn(0, 1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 5, "ld_10_bp");

    // Range boundaries.
    txn(0, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 0, "st_0");
    txn(0, 1'b1, 64'hF8, 64'h5A5A_A5A5_0F0F_F0F0, 64'h0, 1'b0, 0, "st_last");
    txn(0, 1'b0, 64'hF8, 64'h0, 64'h5A5A_A5A5_0F0F_F0F0, 1'b0, 0, "ld_last");
    txn(0, 1'b0, 64'h100, 64'h0, 64'h0, 1'b1, 2, "ld_oor");
    txn(0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, "st_oor_hi");
    txn(0, 1'b0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, "ld_0_unchanged");

    // Misaligned store.
`ifdef LEGV8_DMEM_ALIGN_CHECK_EN
    txn(0, 1'b1, 64'h13, 64'h5555_6666_7777_8888, 64'h0, 1'b1, 0, "st_mis");
    txn(0, 1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0, "ld_10_after_mis");
    txn(0, 1'b0, 64'h17, 64'h0, 64'h0, 1'b1, 0, "ld_mis");
`else
    txn(0, 1'b1, 64'h13, 64'h5555_6666_7777_8888, 64'h0, 1'b0, 0, "st_mis");
    txn(0, 1'b0, 64'h10, 64'h0, 64'h5555_6666_7777_8888, 1'b0, 0, "ld_10_after_mis");
    txn(0, 1'b0, 64'h17, 64'h0, 64'h5555_6666_7777_8888, 1'b0, 0, "ld_mis");
`endif

    // Reset mid-WAIT on the LATENCY=4 instance discards the store.
    txn(1, 1'b1, 64'h8, 64'hAAAA, 64'h0, 1'b0, 0, "l4_prior");
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 64'h8;
    req_wdata[1] = 64'h1111;
    @(negedge clk);                       // acceptance edge has passed
    req_valid[1] = 1'b0;
    check("l4_abort.accepted", 64'(req_ready_o[1]), 64'd0);
    rst[1] = 1'b1;                        // sampled one edge after acceptance
    @(negedge clk);
    rst[1] = 1'b0;
    check("l4_abort.req_ready", 64'(req_ready_o[1]), 64'd1);
    check("l4_abort.resp_valid", 64'(resp_valid_o[1]), 64'd0);
    repeat (6) @(negedge clk);
    check("l4_abort.no_late_resp", 64'(resp_valid_o[1]), 64'd0);
    txn(1, 1'b0, 64'h8, 64'h0, 64'hAAAA, 1'b0, 0, "l4_ld_prior");

    // LATENCY=1 back-to-back with REQ_VALID and RESP_READY held high.
    issued    = 0;
    done      = 0;
    first_acc = -1;
    last_hs   = -1;
    resp_ready[2] = 1'b1;
    for (int t = 0; t < 80 && done < 4; t++) begin
      @(negedge clk);
      if (issued == 4) req_valid[2] = 1'b0;
      if (resp_valid_o[2]) begin
        e = sb.pop_front();
        check($sformatf("tp%0d.rdata", done), resp_rdata_o[2], e.rdata);
        check($sformatf("tp%0d.err", done), 64'(resp_err_o[2]), 64'(e.err));
        check($sformatf("tp%0d.req_ready_in_resp", done), 64'(req_ready_o[2]), 64'd0);
        done++;
        if (done == 4) last_hs = t;
      end
      if (req_ready_o[2] && issued < 4) begin
        req_valid[2] = 1'b1;
        req_write[2] = tp_wr[issued];
        req_addr[2]  = tp_addr[issued];
        req_wdata[2] = tp_data[issued];
        sb.push_back('{rdata: tp_exp[issued], err: 1'b0});
        if (first_acc < 0) first_acc = t;
        issued++;
      end
    end
    req_valid[2]  = 1'b0;
    resp_ready[2] = 1'b0;
    check("tp.done", 64'(done), 64'd4);
    check("tp.cycles", 64'(last_hs - first_acc + 1), 64'd12);
    check("sb.empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
